operand_bypass: RTL and testbench
=================================

Name: operand_bypass

Overview:
- Downstream consumer of the 16-entry register file.
- Takes the file's registered read data one cycle after the read addresses are issued and corrects it for three cases:
  - a write committing on the same edge as the read (the file returns the old value);
  - in-flight results from the execute (EX) and writeback (WB) stages;
  - reads of r15, since the PC lives in its own module.
- Detects load-use hazards and stalls decode until the load result reaches writeback.

Parameters:
ADDR_WIDTH, 4, register address width; must match the register file.
DATA_WIDTH, 32, operand width (`FULLW).
PC_OFFSET, 8, value added to pc_val when r15 is read (ARM pipeline view).

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
rd_en  input  1  decode issues a read this cycle
ra1  input  ADDR_WIDTH  operand-1 address, same value driven to register file in1
ra2  input  ADDR_WIDTH  operand-2 address, same value driven to register file in2
rf_out1  input  DATA_WIDTH  register file out1 (valid one cycle after ra1)
rf_out2  input  DATA_WIDTH  register file out2
wb_we  input  1  writeback write enable (same net as register file we)
wb_wa  input  ADDR_WIDTH  writeback address
wb_wd  input  DATA_WIDTH  writeback data
ex_we  input  1  instruction in EX writes a register
ex_wa  input  ADDR_WIDTH  EX destination
ex_wd  input  DATA_WIDTH  EX ALU result (ignored when ex_is_load)
ex_is_load  input  1  EX instruction is a load; its data is not yet available
pc_val  input  DATA_WIDTH  current PC of the reading instruction
op1  output  DATA_WIDTH  corrected operand 1
op2  output  DATA_WIDTH  corrected operand 2
op_valid  output  1  op1/op2 valid this cycle
stall  output  1  decode must hold ra1/ra2/rd_en and re-present them

Behaviour:
- State: pending_q, a1_q, a2_q, hit1_q/hit2_q, fix1_q/fix2_q. All are cleared to 0 by reset.
- While reset is high, op_valid = 0, stall = 0, op1 = op2 = 0.
- Issue (cycle N, stall = 0):
  - pending_q <= rd_en; a1_q <= ra1; a2_q <= ra2.
  - hit1_q <= wb_we && wb_wa == ra1 && ra1 != 15; fix1_q <= wb_wd.
  - Same rules for operand 2.
- Result (cycle N+1), evaluated combinationally from state and inputs. Select per operand in strict priority (operand 1 shown; operand 2 identical with a2_q):
  1. a1_q == 15 -> pc_val + PC_OFFSET, modulo 2^DATA_WIDTH.
  2. ex_we && !ex_is_load && ex_wa == a1_q -> ex_wd.
  3. wb_we && wb_wa == a1_q -> wb_wd.
  4. hit1_q -> fix1_q.
  5. otherwise -> rf_out1.
- Load-use hazard:
  - stall = pending_q && ex_we && ex_is_load && ((ex_wa == a1_q && a1_q != 15) || (ex_wa == a2_q && a2_q != 15)).
  - op_valid = pending_q && !stall. op1 = op2 = 0 whenever op_valid = 0.
- While stall = 1:
  - a1_q/a2_q/pending_q hold; rd_en/ra1/ra2 are ignored.
  - hit/fix are refreshed: hit1_q <= hit1_q || (wb_we && wb_wa == a1_q && a1_q != 15). fix1_q takes wb_wd when the write matches, so the newest write wins.
- Stall length is unbounded; it releases the first cycle the hazard condition is false.
- Writes to address 15 never match for forwarding or hit capture. Branches are handled by the PC module.
- Simultaneous EX and WB match on the same address: EX wins (younger instruction).
- Back-to-back reads: a new issue in cycle N+1 overwrites state while cycle N+1 outputs still reflect the old state. Full throughput is one read per cycle.
- Reset mid-stall: at the reset edge the pending read is discarded; op_valid stays 0 until a fresh rd_en.
- Latency: operands valid exactly one cycle after issue when no hazard, otherwise one cycle after stall deasserts.

Test Plan:
- Plain read: r3 = 0x11, rd_en with ra1 = 3, ra2 = 4 (r4 = 0x22), no writes -> next cycle op_valid = 1, op1 = 0x11, op2 = 0x22.
- Same-edge collision: rd_en ra1 = 5 while wb_we, wb_wa = 5, wb_wd = 0xDEADBEEF; rf_out1 returns old 0x0 -> next cycle op1 = 0xDEADBEEF.
- EX-over-WB priority: result cycle with ex_wa = 2, ex_wd = 0xAA and wb_wa = 2, wb_wd = 0xBB -> op1 = 0xAA. Repeat with ex_we = 0 -> op1 = 0xBB.
- PC read: ra2 = 15, pc_val = 0x100 -> op2 = 0x108. pc_val = 0xFFFFFFFC -> op2 = 0x4.
- Load-use: result cycle with ex_is_load, ex_wa = 7, a1_q = 7 -> stall = 1, op_valid = 0, op1 = 0. Next cycle wb_we, wb_wa = 7, wb_wd = 0x55 and EX no longer matching -> stall = 0, op_valid = 1, op1 = 0x55. Altered ra1 during the stall is ignored.
- Reset during stall: assert reset for one cycle mid-stall -> stall = op_valid = 0 during reset and after; no operand delivered until the next rd_en.

Source files
------------

// File: rtl/operand_bypass.sv
// Operand correction stage behind the 16-entry register file: merges same-edge writes,
// EX/WB forwarding and the PC view of r15, and stalls decode on load-use hazards.
module operand_bypass #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PC_OFFSET  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  input  logic [DATA_WIDTH-1:0] rf_out1,
  input  logic [DATA_WIDTH-1:0] rf_out2,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_wa,
  input  logic [DATA_WIDTH-1:0] wb_wd,
  input  logic                  ex_we,
  input  logic [ADDR_WIDTH-1:0] ex_wa,
  input  logic [DATA_WIDTH-1:0] ex_wd,
  input  logic                  ex_is_load,
  input  logic [DATA_WIDTH-1:0] pc_val,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  output logic                  op_valid,
  output logic                  stall
);

  localparam logic [ADDR_WIDTH-1:0] PC_REG = ADDR_WIDTH'(15);

  // PC as seen by the reading instruction; wraps modulo 2^DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] pc_view(input logic [DATA_WIDTH-1:0] pc);
    return pc + DATA_WIDTH'(PC_OFFSET);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] select_operand(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  hit,
    input logic [DATA_WIDTH-1:0] fix,
    input logic [DATA_WIDTH-1:0] rf,
    input logic [DATA_WIDTH-1:0] pc_read,
    input logic                  ex_fwd,
    input logic [ADDR_WIDTH-1:0] ex_a,
    input logic [DATA_WIDTH-1:0] ex_d,
    input logic                  wb_w,
    input logic [ADDR_WIDTH-1:0] wb_a,
    input logic [DATA_WIDTH-1:0] wb_d
  );
    if (a == PC_REG)               return pc_read;
    else if (ex_fwd && ex_a == a)  return ex_d;
    else if (wb_w && wb_a == a)    return wb_d;
    else if (hit)                  return fix;
    else                           return rf;
  endfunction

  logic                  pending_q;
  logic [ADDR_WIDTH-1:0] a1_q, a2_q;
  logic                  hit1_q, hit2_q;
  logic [DATA_WIDTH-1:0] fix1_q, fix2_q;

  logic                  haz1, haz2, stall_raw;
  logic                  wm1_issue, wm2_issue, wm1_hold, wm2_hold;
  logic [DATA_WIDTH-1:0] sel1, sel2;

  // Result stage: state captured at issue plus this cycle's EX/WB/PC inputs
  assign haz1      = ex_wa == a1_q && a1_q != PC_REG;
  assign haz2      = ex_wa == a2_q && a2_q != PC_REG;
  assign stall_raw = pending_q && ex_we && ex_is_load && (haz1 || haz2);
  assign stall     = !reset && stall_raw;
  assign op_valid  = !reset && pending_q && !stall_raw;

  assign sel1 = select_operand(a1_q, hit1_q, fix1_q, rf_out1, pc_view(pc_val),
                               ex_we && !ex_is_load, ex_wa, ex_wd, wb_we, wb_wa, wb_wd);
  assign sel2 = select_operand(a2_q, hit2_q, fix2_q, rf_out2, pc_view(pc_val),
                               ex_we && !ex_is_load, ex_wa, ex_wd, wb_we, wb_wa, wb_wd);

  assign op1 = op_valid ? sel1 : '0;
  assign op2 = op_valid ? sel2 : '0;

  // A write on the issue edge lands in the file but the file still returns the old value,
  // so it is captured here; while stalled, later writes keep refreshing the capture.
  assign wm1_issue = wb_we && wb_wa == ra1  && ra1  != PC_REG;
  assign wm2_issue = wb_we && wb_wa == ra2  && ra2  != PC_REG;
  assign wm1_hold  = wb_we && wb_wa == a1_q && a1_q != PC_REG;
  assign wm2_hold  = wb_we && wb_wa == a2_q && a2_q != PC_REG;

  // Issue stage: capture read request and same-edge write collisions
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      a1_q      <= '0;
      a2_q      <= '0;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      fix1_q    <= '0;
      fix2_q    <= '0;
    end else if (stall_raw) begin
      hit1_q <= hit1_q || wm1_hold;
      hit2_q <= hit2_q || wm2_hold;
      if (wm1_hold) fix1_q <= wb_wd;
      if (wm2_hold) fix2_q <= wb_wd;
    end else begin
      pending_q <= rd_en;
      a1_q      <= ra1;
      a2_q      <= ra2;
      hit1_q    <= wm1_issue;
      hit2_q    <= wm2_issue;
      fix1_q    <= wb_wd;
      fix2_q    <= wb_wd;
    end
  end

endmodule

// File: tb/tb_operand_bypass.sv
// Bench for operand_bypass: emulates the register file, predicts architectural operand
// values from committed state plus in-flight producers, and scoreboards the outputs.
module tb_operand_bypass;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_en = 1'b0;
  logic [3:0]  ra1 = '0, ra2 = '0, wb_wa = '0, ex_wa = '0;
  logic [31:0] rf_out1 = '0, rf_out2 = '0, wb_wd = '0, ex_wd = '0, pc_val = '0;
  logic        wb_we = 1'b0, ex_we = 1'b0, ex_is_load = 1'b0;
  logic [31:0] op1, op2;
  logic        op_valid, stall;

  int n_chk = 0;
  int n_fail = 0;

  operand_bypass #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .PC_OFFSET(8)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
    .rf_out1(rf_out1), .rf_out2(rf_out2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .ex_we(ex_we), .ex_wa(ex_wa), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
    .pc_val(pc_val), .op1(op1), .op2(op2), .op_valid(op_valid), .stall(stall)
  );

  always #5 clk = ~clk;

  // Register file: registered read returning the pre-write value on a colliding edge
  logic [31:0] mem [16];
  always @(posedge clk) begin
    rf_out1 <= mem[ra1];
    rf_out2 <= mem[ra2];
    if (wb_we) mem[wb_wa] <= wb_wd;
  end

  // Reference model: one outstanding read, resolved to architectural values
  logic        out_pend = 1'b0;
  logic [3:0]  o_a1 = '0, o_a2 = '0;
  logic        exp_stall = 1'b0, exp_valid = 1'b0;
  logic [63:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_val(input logic [3:0] a);
    if (a == 4'd15) return pc_val + 32'd8;
    if (ex_we && !ex_is_load && ex_wa == a) return ex_wd;
    if (wb_we && wb_wa == a) return wb_wd;
    return mem[a];
  endfunction

  function automatic logic hz_now();
    return !reset && out_pend && ex_we && ex_is_load &&
           ((ex_wa == o_a1 && o_a1 != 4'd15) || (ex_wa == o_a2 && o_a2 != 4'd15));
  endfunction

  task automatic step();
    logic hz;
    if (reset) begin
      out_pend  = 1'b0;
      exp_stall = 1'b0;
      exp_valid = 1'b0;
    end else begin
      hz        = hz_now();
      exp_stall = hz;
      exp_valid = out_pend && !hz;
      if (exp_valid) exp_q.push_back({ref_val(o_a1), ref_val(o_a2)});
      if (!hz) begin
        out_pend = rd_en;
        o_a1     = ra1;
        o_a2     = ra2;
      end
    end
  endtask

  task automatic clr();
    reset = 1'b0; rd_en = 1'b0; ra1 = '0; ra2 = '0;
    wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
    ex_we = 1'b0; ex_wa = '0; ex_wd = '0; ex_is_load = 1'b0; pc_val = '0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    step();
    #4;
  endtask

  function automatic logic [3:0] raddr();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
  endfunction

  // Monitor: compares control every cycle and pops the scoreboard on each delivered operand pair
  always @(negedge clk) begin
    logic [63:0] e;
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("op_valid", 32'(op_valid), 32'(exp_valid));
    if (op_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_op", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("op1", op1, e[63:32]);
        chk("op2", op2, e[31:0]);
      end
    end else begin
      chk("op1_idle", op1, 32'd0);
      chk("op2_idle", op2, 32'd0);
    end
  end

  initial begin
    adv();
    // Preload the file while held in reset
    for (int i = 0; i < 16; i++) begin
      clr();
      reset = 1'b1;
      rd_en = 1'b1; ra1 = 4'(i); ra2 = 4'd15;
      wb_we = 1'b1; wb_wa = 4'(i);
      case (i)
        2: wb_wd = 32'h33;
        3: wb_wd = 32'h11;
        4: wb_wd = 32'h22;
        5: wb_wd = 32'h0;
        default: wb_wd = 32'h01010101 * 32'(i);
      endcase
      settle();
      if (i == 1) begin
        chk("rst_valid", 32'(op_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_op2", op2, 32'd0);
      end
      adv();
    end

    // Plain read
    clr(); rd_en = 1'b1; ra1 = 4'd3; ra2 = 4'd4; settle(); adv();
    clr(); settle();
    chk("plain_valid", 32'(op_valid), 32'd1);
    chk("plain_op1", op1, 32'h11);
    chk("plain_op2", op2, 32'h22);
    adv();

    // Same-edge collision
    clr(); rd_en = 1'b1; ra1 = 4'd5; ra2 = 4'd4;
    wb_we = 1'b1; wb_wa = 4'd5; wb_wd = 32'hDEADBEEF; settle(); adv();
    clr(); settle();
    chk("collide_op1", op1, 32'hDEADBEEF);
    adv();

    // EX over WB, then WB alone (back-to-back issue)
    clr(); rd_en = 1'b1; ra1 = 4'd2; ra2 = 4'd3; settle(); adv();
    clr(); rd_en = 1'b1; ra1 = 4'd2; ra2 = 4'd3;
    ex_we = 1'b1; ex_wa = 4'd2; ex_wd = 32'hAA;
    wb_we = 1'b1; wb_wa = 4'd2; wb_wd = 32'hBB; settle();
    chk("ex_over_wb_op1", op1, 32'hAA);
    chk("ex_over_wb_op2", op2, 32'h11);
    adv();
    clr(); wb_we = 1'b1; wb_wa = 4'd2; wb_wd = 32'hBB; settle();
    chk("wb_only_op1", op1, 32'hBB);
    adv();

    // PC reads, including wrap
    clr(); rd_en = 1'b1; ra1 = 4'd3; ra2 = 4'd15; settle(); adv();
    clr(); rd_en = 1'b1; ra1 = 4'd3; ra2 = 4'd15; pc_val = 32'h100; settle();
    chk("pc_op2", op2, 32'h108);
    adv();
    clr(); pc_val = 32'hFFFFFFFC; settle();
    chk("pc_wrap_op2", op2, 32'h4);
    chk("pc_wrap_op1", op1, 32'h11);
    adv();

    // Load-use stall; ra1 altered during the stall must be ignored
    clr(); rd_en = 1'b1; ra1 = 4'd7; ra2 = 4'd4; settle(); adv();
    clr(); rd_en = 1'b1; ra1 = 4'd9; ra2 = 4'd4;
    ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 4'd7; settle();
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_valid", 32'(op_valid), 32'd0);
    chk("lu_op1", op1, 32'd0);
    adv();
    clr(); ra2 = 4'd4; wb_we = 1'b1; wb_wa = 4'd7; wb_wd = 32'h55; settle();
    chk("lu_rel_stall", 32'(stall), 32'd0);
    chk("lu_rel_valid", 32'(op_valid), 32'd1);
    chk("lu_rel_op1", op1, 32'h55);
    chk("lu_rel_op2", op2, 32'h22);
    adv();

    // Reset in the middle of a stall
    clr(); rd_en = 1'b1; ra1 = 4'd6; ra2 = 4'd6; settle(); adv();
    clr(); ra1 = 4'd6; ra2 = 4'd6; ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 4'd6; settle();
    chk("rs_stall", 32'(stall), 32'd1);
    adv();
    clr(); reset = 1'b1; ra1 = 4'd6; ra2 = 4'd6; ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 4'd6; settle();
    chk("rs_in_stall", 32'(stall), 32'd0);
    chk("rs_in_valid", 32'(op_valid), 32'd0);
    adv();
    clr(); ra1 = 4'd6; ra2 = 4'd6; ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 4'd6; settle();
    chk("rs_after_stall", 32'(stall), 32'd0);
    chk("rs_after_valid", 32'(op_valid), 32'd0);
    adv();
    clr(); settle();
    chk("rs_idle_valid", 32'(op_valid), 32'd0);
    adv();

    // Random traffic; decode holds its read while the stall is visible
    for (int i = 0; i < 3000; i++) begin
      clr();
      reset      = ($urandom_range(0, 99) == 0);
      rd_en      = ($urandom_range(0, 3) != 0);
      ra1        = raddr();
      ra2        = raddr();
      wb_we      = 1'($urandom_range(0, 1));
      wb_wa      = raddr();
      wb_wd      = $urandom;
      ex_we      = 1'($urandom_range(0, 1));
      ex_wa      = raddr();
      ex_wd      = $urandom;
      ex_is_load = ($urandom_range(0, 2) == 0);
      pc_val     = $urandom;
      if (hz_now()) begin
        ra1 = o_a1;
        ra2 = o_a2;
      end
      step();
      adv();
    end

    // Drain and confirm every predicted operand pair was delivered
    clr(); step(); adv();
    clr(); step(); adv();
    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
